// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system-ID word and build timestamp,
// checks both against build-time constants and reports pass/fail/timeout.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID  = 32'd0,
  parameter logic [31:0] EXPECTED_TS  = 32'd1520954411,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);
  localparam int          LAT_LAST_I = (READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0;
  localparam logic [2:0]  LAT_LAST   = 3'(LAT_LAST_I);

  state_t      r_state;
  logic [15:0] r_stall_cnt;
  logic [2:0]  r_lat_cnt;
  logic        r_address;
  logic        r_read;
  logic        r_busy;
  logic        r_done;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  state_t      w_state_nxt;
  logic        w_accept;
  logic        w_stall_hit;
  logic        w_lat_hit;
  logic        w_cap_id;
  logic        w_cap_ts;
  logic        w_tmo;
  logic [15:0] w_stall_nxt;
  logic [2:0]  w_lat_nxt;
  logic        w_address_nxt;
  logic        w_read_nxt;
  logic        w_busy_nxt;
  logic        w_done_nxt;
  logic        w_id_ok_nxt;
  logic        w_ts_ok_nxt;
  logic        w_timeout_nxt;
  logic [31:0] w_id_value_nxt;
  logic [31:0] w_ts_value_nxt;

  assign w_accept    = r_read & ~waitrequest;
  assign w_stall_hit = r_read & waitrequest & (r_stall_cnt == STALL_LAST);
  assign w_lat_hit   = (r_lat_cnt == LAT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= 16'd0;
      r_lat_cnt   <= 3'd0;
      r_address   <= 1'b0;
      r_read      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_id_ok     <= 1'b0;
      r_ts_ok     <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= 32'd0;
      r_ts_value  <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_address   <= w_address_nxt;
      r_read      <= w_read_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_id_ok     <= w_id_ok_nxt;
      r_ts_ok     <= w_ts_ok_nxt;
      r_timeout   <= w_timeout_nxt;
      r_id_value  <= w_id_value_nxt;
      r_ts_value  <= w_ts_value_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap_id    = 1'b0;
    w_cap_ts    = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = S_RD_ID;
        else       w_state_nxt = r_state;
      end
      S_RD_ID: begin
        // Acceptance wins over timeout on the final allowed cycle.
        if (w_accept) begin
          if (READ_LATENCY == 0) begin
            w_cap_id    = 1'b1;
            w_state_nxt = S_RD_TS;
          end else begin
            w_state_nxt = S_WAIT_ID;
          end
        end else if (w_stall_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_ID;
        end
      end
      S_WAIT_ID: begin
        if (w_lat_hit) begin
          w_cap_id    = 1'b1;
          w_state_nxt = S_RD_TS;
        end else begin
          w_state_nxt = S_WAIT_ID;
        end
      end
      S_RD_TS: begin
        if (w_accept) begin
          if (READ_LATENCY == 0) begin
            w_cap_ts    = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT_TS;
          end
        end else if (w_stall_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RD_TS;
        end
      end
      S_WAIT_TS: begin
        if (w_lat_hit) begin
          w_cap_ts    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT_TS;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_state_nxt != r_state) w_stall_nxt = 16'd0;
    else if (r_read && waitrequest) w_stall_nxt = r_stall_cnt + 16'd1;
    else w_stall_nxt = r_stall_cnt;

    if ((w_state_nxt == r_state) && ((r_state == S_WAIT_ID) || (r_state == S_WAIT_TS)))
      w_lat_nxt = r_lat_cnt + 3'd1;
    else
      w_lat_nxt = 3'd0;
  end

  always_comb begin
    w_id_value_nxt = w_cap_id ? readdata : r_id_value;
    w_ts_value_nxt = w_cap_ts ? readdata : r_ts_value;
    w_read_nxt     = (w_state_nxt == S_RD_ID) || (w_state_nxt == S_RD_TS);
    w_address_nxt  = (w_state_nxt == S_RD_TS) || (w_state_nxt == S_WAIT_TS);
    w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
    w_done_nxt     = (w_state_nxt == S_DONE);
    // Flags are evaluated once on DONE entry, held in DONE, cleared on restart.
    if (w_state_nxt == S_DONE) begin
      if (r_state != S_DONE) begin
        w_id_ok_nxt   = ~w_tmo & (w_id_value_nxt == EXPECTED_ID);
        w_ts_ok_nxt   = ~w_tmo & (w_ts_value_nxt == EXPECTED_TS);
        w_timeout_nxt = w_tmo;
      end else begin
        w_id_ok_nxt   = r_id_ok;
        w_ts_ok_nxt   = r_ts_ok;
        w_timeout_nxt = r_timeout;
      end
    end else begin
      w_id_ok_nxt   = 1'b0;
      w_ts_ok_nxt   = 1'b0;
      w_timeout_nxt = 1'b0;
    end
  end

  assign address  = r_address;
  assign read     = r_read;
  assign busy     = r_busy;
  assign done     = r_done;
  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

endmodule

// File: tb/tb_sysid_reader.sv
// Directed bench for sysid_reader: four instances cover zero latency, latency 2,
// a short timeout and latency 3 with a mid-sequence reset.
module tb_sysid_reader;

  localparam logic [31:0] TS = 32'd1520954411;

  logic clk;
  logic rst_n;
  logic rst3;
  int   n_checks;
  int   n_err;

  logic start0, addr0, read0, wait0, busy0, done0, idok0, tsok0, tmo0;
  logic [31:0] rd0, idv0, tsv0, id_word0;
  logic start1, addr1, read1, busy1, done1, idok1, tsok1, tmo1;
  logic [31:0] rd1, idv1, tsv1;
  logic start2, addr2, read2, wait2, busy2, done2, idok2, tsok2, tmo2;
  logic [31:0] idv2, tsv2;
  logic start3, addr3, read3, busy3, done3, idok3, tsok3, tmo3;
  logic [31:0] rd3, idv3, tsv3;
  logic [1:0] pv1, pa1;
  logic [2:0] pv3, pa3;

  sysid_reader #(.READ_LATENCY(0), .TIMEOUT(255)) u0 (
    .clock(clk), .reset_n(rst_n), .start(start0), .address(addr0), .read(read0),
    .waitrequest(wait0), .readdata(rd0), .busy(busy0), .done(done0), .id_ok(idok0),
    .ts_ok(tsok0), .timeout(tmo0), .id_value(idv0), .ts_value(tsv0));

  sysid_reader #(.READ_LATENCY(2), .TIMEOUT(255)) u1 (
    .clock(clk), .reset_n(rst_n), .start(start1), .address(addr1), .read(read1),
    .waitrequest(1'b0), .readdata(rd1), .busy(busy1), .done(done1), .id_ok(idok1),
    .ts_ok(tsok1), .timeout(tmo1), .id_value(idv1), .ts_value(tsv1));

  sysid_reader #(.READ_LATENCY(0), .TIMEOUT(8)) u2 (
    .clock(clk), .reset_n(rst_n), .start(start2), .address(addr2), .read(read2),
    .waitrequest(wait2), .readdata(32'h12345678), .busy(busy2), .done(done2), .id_ok(idok2),
    .ts_ok(tsok2), .timeout(tmo2), .id_value(idv2), .ts_value(tsv2));

  sysid_reader #(.READ_LATENCY(3), .TIMEOUT(255)) u3 (
    .clock(clk), .reset_n(rst3), .start(start3), .address(addr3), .read(read3),
    .waitrequest(1'b0), .readdata(rd3), .busy(busy3), .done(done3), .id_ok(idok3),
    .ts_ok(tsok3), .timeout(tmo3), .id_value(idv3), .ts_value(tsv3));

  always #5 clk = ~clk;

  // Zero-latency slave answers combinationally from the address.
  assign rd0 = addr0 ? TS : id_word0;

  // Latency-2 slave: data valid only two cycles after acceptance, garbage otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv1 <= 2'd0;
      pa1 <= 2'd0;
    end else begin
      pv1 <= {pv1[0], read1};
      pa1 <= {pa1[0], addr1};
    end
  end
  assign rd1 = pv1[1] ? (pa1[1] ? TS : 32'd0) : 32'hFFFFFFFF;

  // Latency-3 slave with the same garbage-when-invalid behaviour.
  always_ff @(posedge clk or negedge rst3) begin
    if (!rst3) begin
      pv3 <= 3'd0;
      pa3 <= 3'd0;
    end else begin
      pv3 <= {pv3[1:0], read3};
      pa3 <= {pa3[1:0], addr3};
    end
  end
  assign rd3 = pv3[2] ? (pa3[2] ? TS : 32'd0) : 32'hFFFFFFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    clk = 1'b0; rst_n = 1'b0; rst3 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    wait0 = 1'b0; wait2 = 1'b1; id_word0 = 32'd0;
    #3;
    chk("rst_read", {31'd0, read0}, 32'd0);
    chk("rst_addr", {31'd0, addr0}, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_done", {31'd0, done0}, 32'd0);
    chk("rst_flags", {29'd0, idok0, tsok0, tmo0}, 32'd0);
    chk("rst_idv", idv0, 32'd0);
    chk("rst_tsv", tsv0, 32'd0);
    tick(); rst_n = 1'b1; rst3 = 1'b1;
    tick(); tick();
    chk("idle_no_read", {31'd0, read0}, 32'd0);

    // Zero-wait, zero-latency pass
    start0 = 1'b1; tick(); start0 = 1'b0;
    chk("t1_c1_read", {31'd0, read0}, 32'd1);
    chk("t1_c1_addr", {31'd0, addr0}, 32'd0);
    chk("t1_c1_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("t1_c2_read", {31'd0, read0}, 32'd1);
    chk("t1_c2_addr", {31'd0, addr0}, 32'd1);
    tick();
    chk("t1_c3_done", {31'd0, done0}, 32'd1);
    chk("t1_c3_idok", {31'd0, idok0}, 32'd1);
    chk("t1_c3_tsok", {31'd0, tsok0}, 32'd1);
    chk("t1_c3_tsv", tsv0, TS);
    chk("t1_c3_busy", {31'd0, busy0}, 32'd0);
    chk("t1_c3_read", {31'd0, read0}, 32'd0);

    // Latency 2
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("t2_read_c%0d", c), {31'd0, read1}, ((c == 1) || (c == 4)) ? 32'd1 : 32'd0);
      if (c == 6) chk("t2_c6_done", {31'd0, done1}, 32'd0);
      if (c < 7) tick();
    end
    chk("t2_c7_done", {31'd0, done1}, 32'd1);
    chk("t2_c7_idok", {31'd0, idok1}, 32'd1);
    chk("t2_c7_tsok", {31'd0, tsok1}, 32'd1);
    chk("t2_c7_idv", idv1, 32'd0);
    chk("t2_c7_tsv", tsv1, TS);
    chk("t2_c7_tmo_busy", {30'd0, tmo1, busy1}, 32'd0);

    // Three stall cycles on the first read
    wait0 = 1'b1; start0 = 1'b1; tick(); start0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("t3_read_c%0d", c), {31'd0, read0}, 32'd1);
      chk($sformatf("t3_addr_c%0d", c), {31'd0, addr0}, 32'd0);
      if (c == 4) wait0 = 1'b0;
      tick();
    end
    chk("t3_c5_done", {31'd0, done0}, 32'd0);
    chk("t3_c5_addr", {31'd0, addr0}, 32'd1);
    tick();
    chk("t3_c6_done", {31'd0, done0}, 32'd1);
    chk("t3_c6_flags", {30'd0, idok0, tsok0}, 32'd3);
    chk("t3_c6_tmo", {31'd0, tmo0}, 32'd0);

    // Stuck waitrequest, TIMEOUT=8
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("t4_read_c%0d", c), {31'd0, read2}, (c <= 8) ? 32'd1 : 32'd0);
      if (c < 9) tick();
    end
    chk("t4_c9_done", {31'd0, done2}, 32'd1);
    chk("t4_c9_tmo", {31'd0, tmo2}, 32'd1);
    chk("t4_c9_flags", {30'd0, idok2, tsok2}, 32'd0);
    chk("t4_c9_values", idv2 | tsv2, 32'd0);
    chk("t4_c9_busy_addr", {30'd0, busy2, addr2}, 32'd0);

    // Wrong ID, then restart from DONE
    id_word0 = 32'd1; start0 = 1'b1; tick(); start0 = 1'b0;
    tick(); tick();
    chk("t5_c3_done", {31'd0, done0}, 32'd1);
    chk("t5_c3_idok", {31'd0, idok0}, 32'd0);
    chk("t5_c3_idv", idv0, 32'd1);
    chk("t5_c3_tsok", {31'd0, tsok0}, 32'd1);
    start0 = 1'b1; tick(); start0 = 1'b0; id_word0 = 32'd0;
    chk("t5_c4_done", {31'd0, done0}, 32'd0);
    chk("t5_c4_flags", {29'd0, idok0, tsok0, tmo0}, 32'd0);
    chk("t5_c4_read", {31'd0, read0}, 32'd1);
    chk("t5_c4_busy", {31'd0, busy0}, 32'd1);
    chk("t5_c4_idv_kept", idv0, 32'd1);
    tick(); tick();
    chk("t5_c6_done", {31'd0, done0}, 32'd1);
    chk("t5_c6_idok", {31'd0, idok0}, 32'd1);
    chk("t5_c6_idv", idv0, 32'd0);

    // Reset during WAIT_TS with latency 3
    start3 = 1'b1; tick(); start3 = 1'b0;
    repeat (6) tick();
    chk("t6_c7_read", {31'd0, read3}, 32'd0);
    chk("t6_c7_addr", {31'd0, addr3}, 32'd1);
    chk("t6_c7_idv", idv3, 32'd0);
    rst3 = 1'b0; #1;
    chk("t6_rst_ctrl", {25'd0, read3, addr3, busy3, done3, idok3, tsok3, tmo3}, 32'd0);
    chk("t6_rst_idv", idv3, 32'd0);
    chk("t6_rst_tsv", tsv3, 32'd0);
    tick(); rst3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t6_idle_read_%0d", c), {30'd0, read3, busy3}, 32'd0);
    end
    start3 = 1'b1; tick(); start3 = 1'b0;
    chk("t6_r_c1_read", {31'd0, read3}, 32'd1);
    repeat (7) tick();
    chk("t6_r_c8_done", {31'd0, done3}, 32'd0);
    tick();
    chk("t6_r_c9_done", {31'd0, done3}, 32'd1);
    chk("t6_r_c9_flags", {30'd0, idok3, tsok3}, 32'd3);
    chk("t6_r_c9_tsv", tsv3, TS);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
